// File: rtl/flit_injector.sv
// Turns a packet request plus a stream of body words into head/body/tail flits for a downstream queue.
// Head is written the cycle after acceptance, body words pass straight through, and full_i stalls every write.
module flit_injector #(
   parameter int DEST_W    = 4,
   parameter int LEN_W     = 4,
   parameter int PAYLOAD_W = 32,
   localparam int FLIT_W   = PAYLOAD_W + 2
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 pkt_valid_i,
   output logic                 pkt_ready_o,
   input  logic [DEST_W-1:0]    pkt_dest_i,
   input  logic [LEN_W-1:0]     pkt_len_i,
   input  logic                 word_valid_i,
   output logic                 word_ready_o,
   input  logic [PAYLOAD_W-1:0] word_data_i,
   input  logic                 full_i,
   output logic                 write_en_o,
   output logic [FLIT_W-1:0]    write_data_o,
   output logic                 busy_o,
   output logic [15:0]          pkt_count_o
);

   typedef enum logic [1:0] {IDLE, HEAD, BODY} state_t;

   localparam logic [1:0] TYPE_BODY      = 2'b00;
   localparam logic [1:0] TYPE_HEAD      = 2'b01;
   localparam logic [1:0] TYPE_TAIL      = 2'b10;
   localparam logic [1:0] TYPE_HEAD_TAIL = 2'b11;

   state_t               state_q, state_d;
   logic [DEST_W-1:0]    dest_q, dest_d;
   logic [LEN_W-1:0]     len_q, len_d;
   logic [LEN_W-1:0]     rem_q, rem_d;
   logic [15:0]          pkt_count_q;
   logic                 pkt_done;
   logic [PAYLOAD_W-1:0] head_payload;

   // Head payload carries the route and length; upper bits stay zero.
   always_comb begin
      head_payload = '0;
      head_payload[LEN_W+DEST_W-1:0] = {len_q, dest_q};
   end

   always_comb begin
      state_d      = state_q;
      dest_d       = dest_q;
      len_d        = len_q;
      rem_d        = rem_q;
      pkt_done     = 1'b0;
      pkt_ready_o  = (state_q == IDLE) && !rst;
      word_ready_o = 1'b0;
      write_en_o   = 1'b0;
      write_data_o = '0;
      case (state_q)
         IDLE: begin
            if (pkt_valid_i && !rst) begin
               dest_d  = pkt_dest_i;
               len_d   = pkt_len_i;
               rem_d   = pkt_len_i;
               state_d = HEAD;
            end
         end
         HEAD: begin
            if (!full_i) begin
               write_en_o = 1'b1;
               if (len_q == '0) begin
                  write_data_o = {TYPE_HEAD_TAIL, head_payload};
                  pkt_done     = 1'b1;
                  state_d      = IDLE;
               end else begin
                  write_data_o = {TYPE_HEAD, head_payload};
                  state_d      = BODY;
               end
            end
         end
         BODY: begin
            word_ready_o = !full_i;
            if (word_valid_i && !full_i) begin
               write_en_o = 1'b1;
               rem_d      = rem_q - LEN_W'(1);
               if (rem_q == LEN_W'(1)) begin
                  write_data_o = {TYPE_TAIL, word_data_i};
                  pkt_done     = 1'b1;
                  state_d      = IDLE;
               end else begin
                  write_data_o = {TYPE_BODY, word_data_i};
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         dest_q      <= '0;
         len_q       <= '0;
         rem_q       <= '0;
         pkt_count_q <= '0;
      end else begin
         state_q <= state_d;
         dest_q  <= dest_d;
         len_q   <= len_d;
         rem_q   <= rem_d;
         if (pkt_done) begin
            pkt_count_q <= pkt_count_q + 16'd1;
         end
      end
   end

   assign busy_o      = (state_q != IDLE);
   assign pkt_count_o = pkt_count_q;

endmodule

// File: tb/tb_flit_injector.sv
// Randomized and directed stimulus against a flit-list scoreboard for flit_injector.
module tb_flit_injector;
   localparam int FW = 34;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          pkt_valid_i = 1'b0;
   logic          pkt_ready_o;
   logic [3:0]    pkt_dest_i = '0;
   logic [3:0]    pkt_len_i = '0;
   logic          word_valid_i = 1'b0;
   logic          word_ready_o;
   logic [31:0]   word_data_i = '0;
   logic          full_i = 1'b0;
   logic          write_en_o;
   logic [FW-1:0] write_data_o;
   logic          busy_o;
   logic [15:0]   pkt_count_o;

   flit_injector #(.DEST_W(4), .LEN_W(4), .PAYLOAD_W(32)) dut (
      .clk          (clk),
      .rst          (rst),
      .pkt_valid_i  (pkt_valid_i),
      .pkt_ready_o  (pkt_ready_o),
      .pkt_dest_i   (pkt_dest_i),
      .pkt_len_i    (pkt_len_i),
      .word_valid_i (word_valid_i),
      .word_ready_o (word_ready_o),
      .word_data_i  (word_data_i),
      .full_i       (full_i),
      .write_en_o   (write_en_o),
      .write_data_o (write_data_o),
      .busy_o       (busy_o),
      .pkt_count_o  (pkt_count_o)
   );

   always #5 clk = ~clk;

   int            n_cmp = 0;
   int            n_err = 0;
   logic [FW-1:0] exp_q[$];
   logic [3:0]    pend_d[$];
   logic [3:0]    pend_l[$];
   logic [31:0]   word_q[$];
   bit            full_sched[$];
   int            gap_pct = 0;
   int            full_pct = 0;
   bit            strict = 1'b0;
   int            cyc = 0;
   int            acc_cyc = -100;
   int            last_tail = -100;
   int            last_wr = -100;
   logic [15:0]   mcnt = '0;

   task automatic check(input string tag, input logic [FW-1:0] act, input logic [FW-1:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", tag, act, exp, cyc);
      end
   endtask

   // Expected flit list of a packet, straight from the flit format rules.
   task automatic add_pkt(input logic [3:0] d, input logic [3:0] l, input bit seq);
      logic [31:0] w;
      pend_d.push_back(d);
      pend_l.push_back(l);
      if (l == 4'd0) begin
         exp_q.push_back({2'b11, 24'h0, l, d});
      end else begin
         exp_q.push_back({2'b01, 24'h0, l, d});
         for (int i = 0; i < int'(l); i++) begin
            w = seq ? (32'hA + 32'(i)) : $urandom;
            word_q.push_back(w);
            exp_q.push_back({(i == int'(l) - 1) ? 2'b10 : 2'b00, w});
         end
      end
   endtask

   task automatic drive_next();
      pkt_valid_i = (pend_d.size() != 0);
      if (pkt_valid_i) begin
         pkt_dest_i = pend_d[0];
         pkt_len_i  = pend_l[0];
      end else begin
         pkt_dest_i = 4'($urandom);
         pkt_len_i  = 4'($urandom);
      end
      word_valid_i = (word_q.size() != 0) && ($urandom_range(99) >= gap_pct);
      word_data_i  = word_valid_i ? word_q[0] : $urandom;
      if (full_sched.size() != 0) full_i = full_sched.pop_front();
      else full_i = ($urandom_range(99) < full_pct);
   endtask

   task automatic step();
      logic [FW-1:0] f;
      bit acc;
      bit cons;
      @(negedge clk);
      cyc++;
      check("pkt_count", FW'(pkt_count_o), FW'(mcnt));
      check("write_while_full", FW'(write_en_o & full_i), 0);
      check("word_ready_while_full", FW'(word_ready_o & full_i), 0);
      check("idle_no_write", FW'(pkt_ready_o & (write_en_o | word_ready_o)), 0);
      check("busy", FW'(busy_o), FW'(!pkt_ready_o));
      if (write_en_o) begin
         if (exp_q.size() == 0) begin
            check("spurious_write", FW'(write_en_o), 0);
         end else begin
            f = exp_q.pop_front();
            check("flit", write_data_o, f);
            if (f[32]) begin
               if (strict) check("head_latency", FW'(cyc - acc_cyc), 1);
               if (last_tail > 0) begin
                  if (strict) check("b2b_gap", FW'(cyc - last_tail), 2);
                  else check("b2b_min_gap", FW'((cyc - last_tail) >= 2), 1);
               end
            end else if (strict) begin
               check("body_consecutive", FW'(cyc - last_wr), 1);
            end
            if (f[33]) begin
               mcnt++;
               last_tail = cyc;
            end
            last_wr = cyc;
         end
      end else begin
         check("quiet_data_zero", write_data_o, 0);
      end
      acc  = pkt_valid_i & pkt_ready_o;
      cons = word_valid_i & word_ready_o;
      @(posedge clk);
      #1;
      if (acc) begin
         void'(pend_d.pop_front());
         void'(pend_l.pop_front());
         acc_cyc = cyc;
      end
      if (cons) void'(word_q.pop_front());
      drive_next();
   endtask

   task automatic run_all(input int maxc);
      int n = 0;
      last_tail = -100;
      last_wr   = -100;
      drive_next();
      while ((pend_d.size() != 0 || exp_q.size() != 0) && n < maxc) begin
         step();
         n++;
      end
      check("drained", FW'(pend_d.size() == 0 && exp_q.size() == 0), 1);
      step();
      step();
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_write_en"}, FW'(write_en_o), 0);
      check({tag, "_write_data"}, write_data_o, 0);
      check({tag, "_word_ready"}, FW'(word_ready_o), 0);
      check({tag, "_pkt_ready"}, FW'(pkt_ready_o), 0);
      check({tag, "_busy"}, FW'(busy_o), 0);
      check({tag, "_pkt_count"}, FW'(pkt_count_o), 0);
   endtask

   initial begin
      int n;
      int start;
      pkt_valid_i  = 1'b1;
      word_valid_i = 1'b1;
      #3;
      check_reset_outputs("por");
      @(posedge clk);
      #2;
      rst = 1'b0;

      // Single-flit packet, then a three-word packet, then back-to-back packets.
      strict = 1'b1;
      add_pkt(4'h3, 4'd0, 1'b0);
      run_all(20);
      add_pkt(4'h5, 4'd3, 1'b1);
      run_all(20);
      add_pkt(4'h9, 4'd2, 1'b0);
      add_pkt(4'h1, 4'd0, 1'b0);
      add_pkt(4'hE, 4'd1, 1'b0);
      run_all(40);

      // Full stalls during HEAD and in the middle of BODY.
      strict = 1'b0;
      full_sched = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
      add_pkt(4'h5, 4'd3, 1'b1);
      run_all(40);

      // Random lengths, word gaps and full stalls.
      gap_pct  = 30;
      full_pct = 25;
      for (int i = 0; i < 40; i++) add_pkt(4'($urandom), 4'($urandom), 1'b0);
      run_all(4000);

      // Reset after the second body flit of a four-word packet.
      gap_pct  = 0;
      full_pct = 0;
      add_pkt(4'hA, 4'd4, 1'b0);
      drive_next();
      n = 0;
      while (exp_q.size() > 2 && n < 30) begin
         step();
         n++;
      end
      check("pre_reset_progress", FW'(exp_q.size()), 2);
      #2;
      rst = 1'b1;
      #1;
      check_reset_outputs("mid_pkt_rst");
      exp_q.delete();
      word_q.delete();
      pend_d.delete();
      pend_l.delete();
      mcnt = '0;
      pkt_valid_i  = 1'b1;
      word_valid_i = 1'b1;
      @(negedge clk);
      check_reset_outputs("rst_held");
      @(posedge clk);
      #2;
      rst = 1'b0;
      strict = 1'b1;
      start = cyc;
      add_pkt(4'h7, 4'd2, 1'b0);
      run_all(20);
      check("first_accept_after_rst", FW'(acc_cyc - start), 1);

      // Counter wrap: preset the count just below the top, then finish two packets.
      #1;
      dut.pkt_count_q = 16'hFFFE;
      mcnt = 16'hFFFE;
      add_pkt(4'h1, 4'd0, 1'b0);
      add_pkt(4'h2, 4'd1, 1'b0);
      run_all(20);
      check("count_wrapped", FW'(pkt_count_o), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: time limit reached before summary");
      $fatal(1);
   end
endmodule
